// File: rtl/harness_rseq_pkg.sv
// Shared types and helpers for the harness reset sequencer.
package harness_rseq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOCK_WAIT = 3'd1,
    POR       = 3'd2,
    STAGGER   = 3'd3,
    RUN       = 3'd4,
    PASS      = 3'd5,
    TIMEOUT   = 3'd6
  } rseq_state_t;

  // Counter widths at or above this cannot overflow any int-sized cycle count.
  localparam int RSEQ_CNT_W_SAFE = 63;

  // True when a CNT_W-bit counter can hold every cycle count the sequencer loads.
  function automatic bit rseq_cnt_w_ok(int w, longint por, longint stg, longint tmo);
    longint mx;
    longint one;
    mx  = por;
    one = 1;
    if (stg > mx) mx = stg;
    if (tmo > mx) mx = tmo;
    return (w >= RSEQ_CNT_W_SAFE) || ((one << w) > mx);
  endfunction

endpackage

// File: rtl/harness_reset_sequencer_countdown.sv
// rseq_countdown: loadable down-counter that parks at zero and flags it.
module rseq_countdown
  import harness_rseq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins; otherwise count down and stay at zero (never wraps).
  always_ff @(posedge i_clk) begin
    if (i_reset)            r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/harness_reset_sequencer.sv
// harness_reset_sequencer: staged multi-domain reset release after clock lock,
// followed by run supervision. Define RSEQ_WDOG_EN to build the RUN watchdog;
// without it RUN waits indefinitely for run_done and timeout stays 0.
module harness_reset_sequencer
  import harness_rseq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int POR_CYC     = 16,
  parameter int STAGGER_CYC = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 32
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_pll_locked,
  input  logic            i_sw_rst_req,
  input  logic            i_run_done,
  output logic [N_CH-1:0] o_rst_out,
  output logic            o_all_released,
  output logic            o_timeout,
  output logic            o_passed,
  output logic [2:0]      o_state
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] STG_LOAD = CNT_W'(STAGGER_CYC - 1);
`ifdef RSEQ_WDOG_EN
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(TIMEOUT_CYC - 1);
`else
  localparam logic [CNT_W-1:0] RUN_LOAD = '0;
`endif

  if (!rseq_cnt_w_ok(CNT_W, POR_CYC, STAGGER_CYC, TIMEOUT_CYC)) begin : g_bad_cnt_w
    $error("harness_reset_sequencer: CNT_W too narrow for POR/STAGGER/TIMEOUT");
  end

  rseq_state_t      r_state, w_state_nxt;
  logic [N_CH-1:0]  r_rst_out, w_rst_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_passed, w_passed_nxt;
  logic             w_load, w_zero, w_abort;
  logic [CNT_W-1:0] w_load_val;

  rseq_countdown #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // State and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_rst_out <= '1;
      r_idx     <= '0;
      r_timeout <= 1'b0;
      r_passed  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_out <= w_rst_nxt;
      r_idx     <= w_idx_nxt;
      r_timeout <= w_timeout_nxt;
      r_passed  <= w_passed_nxt;
    end
  end

  // Next-state, release sequencing, and counter reload on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_nxt     = r_rst_out;
    w_idx_nxt     = r_idx;
    w_timeout_nxt = r_timeout;
    w_passed_nxt  = r_passed;
    w_load        = 1'b0;
    w_load_val    = '0;
    w_abort       = !i_pll_locked || i_sw_rst_req;

    case (r_state)
      IDLE:      w_state_nxt = LOCK_WAIT;
      LOCK_WAIT: if (!w_abort) w_state_nxt = POR;
      POR: if (w_zero) begin
        w_rst_nxt[0] = 1'b0;
        w_idx_nxt    = IDX_W'(1);
        w_state_nxt  = (N_CH == 1) ? RUN : STAGGER;
      end
      STAGGER: if (w_zero) begin
        w_rst_nxt[r_idx] = 1'b0;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = RUN;
        end else begin
          w_idx_nxt  = IDX_W'(r_idx + 1'b1);
          w_load     = 1'b1;
          w_load_val = STG_LOAD;
        end
      end
      RUN: begin
        // run_done on the final watchdog cycle still counts as a pass.
        if (i_run_done) begin
          w_state_nxt  = PASS;
          w_passed_nxt = 1'b1;
        end
`ifdef RSEQ_WDOG_EN
        else if (w_zero) begin
          w_state_nxt   = TIMEOUT;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // Lock loss or software request restarts the whole sequence.
    if (w_abort && r_state != IDLE && r_state != LOCK_WAIT) begin
      w_state_nxt   = LOCK_WAIT;
      w_rst_nxt     = '1;
      w_idx_nxt     = '0;
      w_timeout_nxt = 1'b0;
      w_passed_nxt  = 1'b0;
    end

    if (w_state_nxt != r_state) begin
      w_load = 1'b1;
      case (w_state_nxt)
        POR:     w_load_val = POR_LOAD;
        STAGGER: w_load_val = STG_LOAD;
        RUN:     w_load_val = RUN_LOAD;
        default: w_load_val = '0;
      endcase
    end
  end

  assign o_rst_out      = r_rst_out;
  assign o_all_released = (r_rst_out == '0);
  assign o_timeout      = r_timeout;
  assign o_passed       = r_passed;
  assign o_state        = r_state;

endmodule

// File: tb/tb_harness_reset_sequencer.sv
// Directed bench for harness_reset_sequencer: expected output snapshots are
// queued with their cycle numbers; a monitor compares them as cycles arrive.
module tb_harness_reset_sequencer;

  localparam int TMO = 100;
`ifdef RSEQ_WDOG_EN
  localparam int T0 = 160;
`else
  localparam int T0 = 10 * TMO + 60;
`endif
  localparam int L = T0 + 215;
  localparam int M = L + 52;
  localparam int N = M + 31;

  logic       clk = 1'b0, rst = 1'b1, locked = 1'b0, sw = 1'b0, done = 1'b0;
  logic [3:0] rst_out;
  logic       all_rel, tmo, pass;
  logic [2:0] st;

  harness_reset_sequencer #(
    .N_CH(4), .POR_CYC(16), .STAGGER_CYC(8), .TIMEOUT_CYC(TMO), .CNT_W(32)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_pll_locked(locked), .i_sw_rst_req(sw),
    .i_run_done(done), .o_rst_out(rst_out), .o_all_released(all_rel),
    .o_timeout(tmo), .o_passed(pass), .o_state(st)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic       a, t, p;
    logic [2:0] s;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic push(int c, logic [3:0] r, logic a, logic t, logic p, logic [2:0] s);
    exp_t e;
    e.cyc = c; e.r = r; e.a = a; e.t = t; e.p = p; e.s = s;
    q.push_back(e);
  endtask

  task automatic at(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL missed_cycle cyc=%0d expected at %0d", cyc, e.cyc);
      end else if (rst_out !== e.r || all_rel !== e.a || tmo !== e.t ||
                   pass !== e.p || st !== e.s) begin
        failures++;
        $display("FAIL outputs@%0d got rst=%h all=%b to=%b pass=%b st=%0d exp rst=%h all=%b to=%b pass=%b st=%0d",
                 cyc, rst_out, all_rel, tmo, pass, st, e.r, e.a, e.t, e.p, e.s);
      end
    end
  end

  initial begin
    // Reset, IDLE, first sequence (lock at cycle 10).
    push(2, 4'hF, 0, 0, 0, 0);  push(3, 4'hF, 0, 0, 0, 0);
    push(4, 4'hF, 0, 0, 0, 1);  push(9, 4'hF, 0, 0, 0, 1);
    push(11, 4'hF, 0, 0, 0, 2); push(26, 4'hF, 0, 0, 0, 2);
    push(27, 4'hE, 0, 0, 0, 3); push(34, 4'hE, 0, 0, 0, 3);
    push(35, 4'hC, 0, 0, 0, 3); push(43, 4'h8, 0, 0, 0, 3);
    push(50, 4'h8, 0, 0, 0, 3); push(51, 4'h0, 1, 0, 0, 4);
`ifdef RSEQ_WDOG_EN
    push(150, 4'h0, 1, 0, 0, 4); push(151, 4'h0, 1, 1, 0, 6);
    push(155, 4'h0, 1, 1, 0, 6);
`else
    push(151, 4'h0, 1, 0, 0, 4); push(51 + 10 * TMO, 4'h0, 1, 0, 0, 4);
`endif
    // Lock loss, relock, run_done -> PASS.
    push(T0 + 1, 4'hF, 0, 0, 0, 1);  push(T0 + 45, 4'h8, 0, 0, 0, 3);
    push(T0 + 46, 4'h0, 1, 0, 0, 4); push(T0 + 86, 4'h0, 1, 0, 0, 4);
    push(T0 + 87, 4'h0, 1, 0, 1, 5); push(T0 + 200, 4'h0, 1, 0, 1, 5);
    // Software reset held 5 cycles in PASS, then re-sequence.
    push(T0 + 211, 4'hF, 0, 0, 0, 1); push(L, 4'hF, 0, 0, 0, 1);
    push(L + 1, 4'hF, 0, 0, 0, 2);    push(L + 16, 4'hF, 0, 0, 0, 2);
    push(L + 17, 4'hE, 0, 0, 0, 3);   push(L + 41, 4'h0, 1, 0, 0, 4);
    // Lock loss mid-STAGGER with two channels released.
    push(L + 51, 4'hF, 0, 0, 0, 1);   push(M + 17, 4'hE, 0, 0, 0, 3);
    push(M + 25, 4'hC, 0, 0, 0, 3);   push(M + 28, 4'hC, 0, 0, 0, 3);
    push(M + 29, 4'hF, 0, 0, 0, 1);   push(M + 30, 4'hF, 0, 0, 0, 1);
    push(N + 16, 4'hF, 0, 0, 0, 2);   push(N + 17, 4'hE, 0, 0, 0, 3);
    push(N + 41, 4'h0, 1, 0, 0, 4);
    // Simultaneous lock loss and software request.
    push(N + 46, 4'hF, 0, 0, 0, 1);   push(N + 47, 4'hF, 0, 0, 0, 2);

    at(3);      rst = 1'b0;
    at(10);     locked = 1'b1;
    at(T0);     locked = 1'b0;
    at(T0 + 5); locked = 1'b1;
    at(T0 + 86); done = 1'b1;
    at(T0 + 87); done = 1'b0;
    at(T0 + 210); sw = 1'b1;
    at(T0 + 215); sw = 1'b0;
    at(L + 50); locked = 1'b0;
    at(L + 52); locked = 1'b1;
    at(M + 28); locked = 1'b0;
    at(M + 31); locked = 1'b1;
    at(N + 45); locked = 1'b0; sw = 1'b1;
    at(N + 46); locked = 1'b1; sw = 1'b0;
    at(N + 50);
    @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained left=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
